// File: rtl/collision_pkg.sv
// Shared types for the ball collision unit: edge codes and the frame-sync FSM states.
package collision_pkg;

  typedef logic [3:0] edge_code_t;

  localparam edge_code_t EDGE_TOP    = 4'b1000;
  localparam edge_code_t EDGE_RIGHT  = 4'b0100;
  localparam edge_code_t EDGE_BOTTOM = 4'b0010;
  localparam edge_code_t EDGE_LEFT   = 4'b0001;

  typedef enum logic {
    SYNC,
    ACCUM
  } col_state_t;

endpackage

// File: rtl/collision_accum.sv
// Per-target edge accumulator with saturating overlap counter and commit register.
// Optional per-target holdoff after a nonzero commit is enabled by COLLISION_HOLDOFF_EN.
module collision_accum
  import collision_pkg::*;
#(
  parameter int MIN_OVERLAP    = 4,
  parameter int CNT_W          = 8,
  parameter int HOLDOFF_FRAMES = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       hit,
  input  edge_code_t hit_edge,
  input  logic       commit,
  input  logic       clear,
  output edge_code_t code
);

  edge_code_t       acc_reg;
  edge_code_t       acc_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  edge_code_t       commit_code;
  logic             hit_eff;

`ifdef COLLISION_HOLDOFF_EN
  localparam int HW = (HOLDOFF_FRAMES < 1) ? 1 : $clog2(HOLDOFF_FRAMES + 1);
  logic [HW-1:0] holdoff_reg;

  assign hit_eff = hit && (holdoff_reg == '0);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      holdoff_reg <= '0;
    end else if (commit || clear) begin
      if (holdoff_reg != '0)
        holdoff_reg <= holdoff_reg - 1'b1;
      else if (commit && (commit_code != '0))
        holdoff_reg <= HW'(HOLDOFF_FRAMES);
    end
  end
`else
  assign hit_eff = hit;
`endif

  // The end_of_frame pixel itself belongs to the ending frame, so commit uses *_next.
  always_comb begin
    acc_next = acc_reg | (hit_eff ? hit_edge : 4'b0000);
    cnt_next = cnt_reg;
    if (hit_eff && (cnt_reg != '1))
      cnt_next = cnt_reg + 1'b1;
    commit_code = (int'(cnt_next) >= MIN_OVERLAP) ? acc_next : 4'b0000;
`ifdef COLLISION_HOLDOFF_EN
    if (holdoff_reg != '0)
      commit_code = 4'b0000;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      acc_reg <= '0;
      cnt_reg <= '0;
      code    <= '0;
    end else if (commit || clear) begin
      acc_reg <= '0;
      cnt_reg <= '0;
      if (commit)
        code <= commit_code;
    end else begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/collision_unit.sv
// Collects ball/border and ball/player overlaps per frame and commits edge codes at end_of_frame.
// Define COLLISION_HOLDOFF_EN to suppress a target for HOLDOFF_FRAMES frames after a nonzero commit.
module collision_unit
  import collision_pkg::*;
#(
  parameter int MIN_OVERLAP    = 4,
  parameter int CNT_W          = 8,
  parameter int HOLDOFF_FRAMES = 2
) (
  input  logic       clk_25,
  input  logic       resetN,
  input  logic       end_of_frame,
  input  logic       ball_draw_request,
  input  edge_code_t ball_hit_edge,
  input  logic       frame_draw_request,
  input  logic       player_draw_request,
  output edge_code_t frame_collision,
  output edge_code_t player_collision,
  output logic       collision_valid
);

  col_state_t state_reg;
  col_state_t state_next;
  logic       commit;
  logic       clear;
  logic       commit_d_reg;

  always_ff @(posedge clk_25) begin
    if (!resetN) begin
      state_reg    <= SYNC;
      commit_d_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      commit_d_reg <= commit;
    end
  end

  // The first frame after reset is partial, so SYNC only clears on end_of_frame.
  always_comb begin
    state_next = state_reg;
    commit     = 1'b0;
    clear      = 1'b0;
    case (state_reg)
      SYNC: begin
        if (end_of_frame) begin
          clear      = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        commit = end_of_frame;
      end
      default: state_next = SYNC;
    endcase
  end

  assign collision_valid = commit_d_reg && ((frame_collision | player_collision) != 4'b0000);

  collision_accum #(
    .MIN_OVERLAP   (MIN_OVERLAP),
    .CNT_W         (CNT_W),
    .HOLDOFF_FRAMES(HOLDOFF_FRAMES)
  ) u_frame_accum (
    .clk     (clk_25),
    .resetN  (resetN),
    .hit     (ball_draw_request && frame_draw_request),
    .hit_edge(ball_hit_edge),
    .commit  (commit),
    .clear   (clear),
    .code    (frame_collision)
  );

  collision_accum #(
    .MIN_OVERLAP   (MIN_OVERLAP),
    .CNT_W         (CNT_W),
    .HOLDOFF_FRAMES(HOLDOFF_FRAMES)
  ) u_player_accum (
    .clk     (clk_25),
    .resetN  (resetN),
    .hit     (ball_draw_request && player_draw_request),
    .hit_edge(ball_hit_edge),
    .commit  (commit),
    .clear   (clear),
    .code    (player_collision)
  );

endmodule

// File: tb/tb_collision_unit.sv
// Self-checking bench for collision_unit: directed frames with literal expectations plus random frames.
// Holdoff scenario is exercised when COLLISION_HOLDOFF_EN is defined.
module tb_collision_unit;

  localparam int MIN_OV  = 4;
  localparam int CNT_W   = 8;
  localparam int HOLD    = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic       clk_25 = 1'b0;
  logic       resetN = 1'b0;
  logic       end_of_frame = 1'b0;
  logic       ball_draw_request = 1'b0;
  logic [3:0] ball_hit_edge = 4'b0;
  logic       frame_draw_request = 1'b0;
  logic       player_draw_request = 1'b0;
  logic [3:0] frame_collision;
  logic [3:0] player_collision;
  logic       collision_valid;

  always #20 clk_25 = ~clk_25;

  collision_unit #(
    .MIN_OVERLAP   (MIN_OV),
    .CNT_W         (CNT_W),
    .HOLDOFF_FRAMES(HOLD)
  ) dut (
    .clk_25             (clk_25),
    .resetN             (resetN),
    .end_of_frame       (end_of_frame),
    .ball_draw_request  (ball_draw_request),
    .ball_hit_edge      (ball_hit_edge),
    .frame_draw_request (frame_draw_request),
    .player_draw_request(player_draw_request),
    .frame_collision    (frame_collision),
    .player_collision   (player_collision),
    .collision_valid    (collision_valid)
  );

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 0;

  // Behavioural model: edge sets and hit counts for the frame in progress.
  bit       synced = 0;
  bit [3:0] f_bits = 0, p_bits = 0;
  int       f_cnt = 0, p_cnt = 0;
  int       f_hold = 0, p_hold = 0;
  bit [3:0] exp_frame = 0, exp_player = 0;
  bit       exp_valid = 0;
  bit       holdoff_on = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit [3:0] frame_result(input bit [3:0] bits, input int cnt, input int hold);
    if (hold > 0) return 4'b0;
    return (cnt >= MIN_OV) ? bits : 4'b0;
  endfunction

  function automatic int next_hold(input int hold, input bit [3:0] result);
    if (hold > 0) return hold - 1;
    return (holdoff_on && result != 0) ? HOLD : 0;
  endfunction

  task automatic model_update(input bit bd, input bit [3:0] e, input bit fd, input bit pd,
                              input bit eof, input bit rst_n);
    bit [3:0] rf, rp;
    if (!rst_n) begin
      synced = 0; f_bits = 0; p_bits = 0; f_cnt = 0; p_cnt = 0;
      f_hold = 0; p_hold = 0; exp_frame = 0; exp_player = 0; exp_valid = 0;
      return;
    end
    if (bd && fd && f_hold == 0) begin
      f_bits |= e;
      f_cnt = (f_cnt < CNT_MAX) ? f_cnt + 1 : CNT_MAX;
    end
    if (bd && pd && p_hold == 0) begin
      p_bits |= e;
      p_cnt = (p_cnt < CNT_MAX) ? p_cnt + 1 : CNT_MAX;
    end
    exp_valid = 0;
    if (eof) begin
      if (synced) begin
        rf = frame_result(f_bits, f_cnt, f_hold);
        rp = frame_result(p_bits, p_cnt, p_hold);
        exp_frame  = rf;
        exp_player = rp;
        exp_valid  = (rf | rp) != 0;
        f_hold = next_hold(f_hold, rf);
        p_hold = next_hold(p_hold, rp);
      end
      synced = 1;
      f_bits = 0; p_bits = 0; f_cnt = 0; p_cnt = 0;
    end
  endtask

  task automatic step(input bit bd, input bit [3:0] e, input bit fd, input bit pd,
                      input bit eof, input bit rst_n);
    ball_draw_request   = bd;
    ball_hit_edge       = e;
    frame_draw_request  = fd;
    player_draw_request = pd;
    end_of_frame        = eof;
    resetN              = rst_n;
    @(posedge clk_25);
    model_update(bd, e, fd, pd, eof, rst_n);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'b0, 0, 0, 0, 1);
  endtask

  task automatic fresh_start();
    step(0, 4'b0, 0, 0, 0, 0);
    step(0, 4'b0, 0, 0, 0, 0);
    idle(2);
    step(0, 4'b0, 0, 0, 1, 1);
    idle(1);
  endtask

  always @(negedge clk_25) begin
    if (check_en) begin
      chk("frame_collision", frame_collision, exp_frame);
      chk("player_collision", player_collision, exp_player);
      chk("collision_valid", {3'b0, collision_valid}, {3'b0, exp_valid});
    end
  end

  initial begin
`ifdef COLLISION_HOLDOFF_EN
    holdoff_on = 1;
`endif
    step(0, 4'b0, 0, 0, 0, 0);
    step(0, 4'b0, 0, 0, 0, 0);
    check_en = 1;
    chk("reset_frame", frame_collision, 4'b0);
    chk("reset_player", player_collision, 4'b0);
    chk("reset_valid", {3'b0, collision_valid}, 4'b0);

    // Partial frame after reset is discarded.
    idle(1);
    for (int i = 0; i < 3; i++) step(1, 4'b0001, 1, 0, 0, 1);
    step(0, 4'b0, 0, 0, 1, 1);
    chk("sync_frame", frame_collision, 4'b0);
    chk("sync_valid", {3'b0, collision_valid}, 4'b0);

    // 5 left + 2 top border hits.
    for (int i = 0; i < 5; i++) begin step(1, 4'b0001, 1, 0, 0, 1); idle(1); end
    for (int i = 0; i < 2; i++) step(1, 4'b1000, 1, 0, 0, 1);
    step(0, 4'b0, 0, 0, 1, 1);
    chk("commit_frame", frame_collision, 4'b1001);
    chk("commit_player", player_collision, 4'b0);
    chk("commit_valid", {3'b0, collision_valid}, 4'b0001);
    idle(1);
    chk("valid_pulse_end", {3'b0, collision_valid}, 4'b0);
    chk("held_frame", frame_collision, 4'b1001);

    // Below threshold on player.
    fresh_start();
    for (int i = 0; i < 3; i++) step(1, 4'b0100, 0, 1, 0, 1);
    step(0, 4'b0, 0, 0, 1, 1);
    chk("under_player", player_collision, 4'b0);
    chk("under_valid", {3'b0, collision_valid}, 4'b0);

    // Fourth hit of both targets lands in the end_of_frame cycle.
    fresh_start();
    for (int i = 0; i < 3; i++) step(1, 4'b0010, 1, 1, 0, 1);
    step(1, 4'b1000, 1, 1, 1, 1);
    chk("eof_hit_frame", frame_collision, 4'b1010);
    chk("eof_hit_player", player_collision, 4'b1010);
    chk("eof_hit_valid", {3'b0, collision_valid}, 4'b0001);

    // Reset mid-frame after 10 hits.
    fresh_start();
    for (int i = 0; i < 10; i++) step(1, 4'b0001, 1, 0, 0, 1);
    step(0, 4'b0, 0, 0, 0, 0);
    chk("midreset_frame", frame_collision, 4'b0);
    for (int i = 0; i < 5; i++) step(1, 4'b0100, 1, 0, 0, 1);
    step(0, 4'b0, 0, 0, 1, 1);
    chk("after_reset_discard", frame_collision, 4'b0);
    for (int i = 0; i < 5; i++) step(1, 4'b0100, 1, 0, 0, 1);
    step(0, 4'b0, 0, 0, 1, 1);
    chk("after_reset_commit", frame_collision, 4'b0100);

`ifdef COLLISION_HOLDOFF_EN
    fresh_start();
    for (int i = 0; i < 5; i++) step(1, 4'b0010, 1, 0, 0, 1);
    step(0, 4'b0, 0, 0, 1, 1);
    chk("hold_commit", frame_collision, 4'b0010);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 5; i++) step(1, 4'b0010, 1, 0, 0, 1);
      step(0, 4'b0, 0, 0, 1, 1);
      chk("hold_suppressed", frame_collision, 4'b0);
    end
    for (int i = 0; i < 5; i++) step(1, 4'b0010, 1, 0, 0, 1);
    step(0, 4'b0, 0, 0, 1, 1);
    chk("hold_released", frame_collision, 4'b0010);
`endif

    // Randomized frames with occasional resets.
    for (int f = 0; f < 80; f++) begin
      int len;
      len = $urandom_range(30, 4);
      for (int c = 0; c < len; c++) begin
        bit rst_n;
        rst_n = ($urandom_range(199, 0) != 0);
        step($urandom_range(1, 0), 4'($urandom_range(15, 0)), $urandom_range(1, 0),
             $urandom_range(1, 0), (c == len - 1), rst_n);
      end
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
